// File: rtl/multicycle_control.sv
// multicycle_control
// Main control unit for the multicycle RV32I core. It decodes the instruction
// register fields, steps each instruction through a Moore FSM, and drives the
// ALU operation code plus every datapath mux select and write enable.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   op, funct3, funct7b5 instruction fields from the instruction register
//   Zero                ALU result-is-zero flag, used only for beq
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite   enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc           datapath mux selects
//   ALUControl          000 AND, 001 OR, 010 ADD, 011 SUB
//   illegal             high while trapped in the ILLEGAL state
//   dbg_state           current state code
//
// State table:
//   state     | meaning
//   FETCH     | read instr at PC, IR <= mem, PC <= PC+4
//   DECODE    | read registers, compute branch target OldPC+imm
//   MEMADR    | compute load/store address rs1+imm
//   MEMREAD   | read data memory at ALUOut
//   MEMWB     | write loaded data to rd
//   MEMWRITE  | write rs2 to data memory at ALUOut
//   EXECUTER  | R-type ALU operation rs1 op rs2
//   EXECUTEI  | I-type ALU operation rs1 op imm
//   ALUWB     | write ALUOut to rd
//   BEQ       | compare rs1-rs2, load branch target if equal
//   JAL       | PC <= target, ALU computes OldPC+4 for the link
//   ILLEGAL   | unsupported instruction, held until reset

module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               RegWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMREAD  = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWRITE = STATE_W'(5),
        S_EXECUTER = STATE_W'(6),
        S_EXECUTEI = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BEQ      = STATE_W'(9),
        S_JAL      = STATE_W'(10),
        S_ILLEGAL  = STATE_W'(15)
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    state_t state_q;
    state_t state_d;

    logic legal_r;
    logic legal_i;

    // funct3 000/110/111 are the only supported ops; 110/111 have no
    // funct7b5=1 variant in the supported R-type subset.
    always_comb begin
        legal_r = (funct3 == 3'b000) ||
                  (((funct3 == 3'b110) || (funct3 == 3'b111)) && !funct7b5);
        legal_i = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end

    function automatic logic [2:0] funct_alu(input logic [2:0] f3, input logic sub);
        logic [2:0] r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = sub ? ALU_SUB : ALU_ADD;
            3'b110:  r = ALU_OR;
            3'b111:  r = ALU_AND;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = ALU_AND;
        RegWrite   = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                PCWrite    = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b10;
                ALUControl = ALU_ADD;
                if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = S_MEMADR;
                end else if ((op == OP_R) && legal_r) begin
                    state_d = S_EXECUTER;
                end else if ((op == OP_I) && legal_i) begin
                    state_d = S_EXECUTEI;
                end else if ((op == OP_BR) && (funct3 == 3'b000)) begin
                    state_d = S_BEQ;
                end else if (op == OP_JAL) begin
                    state_d = S_JAL;
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                // Only lw and sw reach here; op[5] separates them.
                ImmSrc     = op[5] ? 2'b01 : 2'b00;
                state_d    = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu(funct3, funct7b5);
                state_d    = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                // addi has no subtract form; instr[30] is immediate data here.
                ALUControl = funct_alu(funct3, 1'b0);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                // Mealy exception: branch taken decided in the same cycle.
                PCWrite    = Zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                PCWrite    = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                ALUControl = ALU_ADD;
                state_d    = S_ILLEGAL;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset aborts immediately: no side effects while it is held.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .illegal(illegal), .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       rw;
        logic       ill;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;
    vec_t  got;

    always_comb got = {dbg_state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, illegal};

    // Expected outputs per state, written from the control table.
    function automatic vec_t mk(int st, logic [2:0] alu, logic [1:0] imm, logic z);
        vec_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.irw = 1; e.sb = 2'b10; e.alu = 3'b010; e.rs = 2'b10; e.pcw = 1; end
            1:  begin e.sa = 2'b01; e.sb = 2'b01; e.imm = 2'b10; e.alu = 3'b010; end
            2:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = 3'b010; e.imm = imm; end
            3:  begin e.adr = 1; end
            4:  begin e.rs = 2'b01; e.rw = 1; end
            5:  begin e.adr = 1; e.mw = 1; end
            6:  begin e.sa = 2'b10; e.alu = alu; end
            7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu; end
            8:  begin e.rw = 1; end
            9:  begin e.sa = 2'b10; e.alu = 3'b011; e.pcw = z; end
            10: begin e.sa = 2'b01; e.sb = 2'b10; e.alu = 3'b010; e.pcw = 1; end
            15: begin e.ill = 1; e.alu = 3'b010; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t mk_rst();
        vec_t e;
        e = mk(0, 3'b000, 2'b00, 1'b0);
        e.pcw = 0; e.irw = 0; e.mw = 0; e.rw = 0; e.ill = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        vec_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL %s: actual state=%0d vec=%h, required state=%0d vec=%h",
                         n, got.st, got, e.st, e);
            end
        end
    end

    task automatic push(string n, vec_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic apply_reset(int n);
        reset = 1'b1;
        repeat (n) begin
            push("reset", mk_rst());
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // Called with the DUT in FETCH at posedge+1; returns at posedge+1 after
    // the last listed state.
    task automatic run(string n, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                       int len, int sts[8], logic [2:0] alu, logic [1:0] imm);
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        for (int i = 0; i < len; i++) begin
            push($sformatf("%s st%0d", n, sts[i]), mk(sts[i], alu, imm, z));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        apply_reset(3);

        run("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4, '{0,1,6,8,0,0,0,0}, 3'b010, 2'b00);
        run("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4, '{0,1,6,8,0,0,0,0}, 3'b011, 2'b00);
        run("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 4, '{0,1,6,8,0,0,0,0}, 3'b001, 2'b00);
        run("ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 4, '{0,1,7,8,0,0,0,0}, 3'b001, 2'b00);
        run("andi",  7'b0010011, 3'b111, 1'b1, 1'b0, 4, '{0,1,7,8,0,0,0,0}, 3'b000, 2'b00);
        run("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, '{0,1,7,8,0,0,0,0}, 3'b010, 2'b00);
        run("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 5, '{0,1,2,3,4,0,0,0}, 3'b000, 2'b00);
        run("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4, '{0,1,2,5,0,0,0,0}, 3'b000, 2'b01);
        run("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, '{0,1,9,0,0,0,0,0}, 3'b000, 2'b00);
        run("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, '{0,1,9,0,0,0,0,0}, 3'b000, 2'b00);
        run("jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 4, '{0,1,10,8,0,0,0,0}, 3'b000, 2'b00);

        run("ill_op0",  7'b0000000, 3'b000, 1'b0, 1'b0, 8, '{0,1,15,15,15,15,15,15}, 3'b000, 2'b00);
        apply_reset(1);
        run("ill_rf3",  7'b0110011, 3'b010, 1'b0, 1'b0, 8, '{0,1,15,15,15,15,15,15}, 3'b000, 2'b00);
        apply_reset(1);
        run("ill_bf3",  7'b1100011, 3'b001, 1'b0, 1'b1, 8, '{0,1,15,15,15,15,15,15}, 3'b000, 2'b00);
        apply_reset(1);
        run("ill_or7",  7'b0110011, 3'b110, 1'b1, 1'b0, 8, '{0,1,15,15,15,15,15,15}, 3'b000, 2'b00);
        apply_reset(1);

        // Reset dropped in the middle of MEMREAD must act without a clock edge.
        run("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 3, '{0,1,2,0,0,0,0,0}, 3'b000, 2'b00);
        push("lw_abort st3", mk(3, 3'b000, 2'b00, 1'b0));
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (dbg_state !== 4'd0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: actual state=%0d rw=%b mw=%b, required state=0 rw=0 mw=0",
                     dbg_state, RegWrite, MemWrite);
        end
        @(posedge clk); #1;
        apply_reset(2);
        run("add_after", 7'b0110011, 3'b000, 1'b0, 1'b0, 4, '{0,1,6,8,0,0,0,0}, 3'b010, 2'b00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d, required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
